lal_seq: RTL

Sequential control stage wrapped around the `lal` combinational next-state logic. It holds the 9-bit step counter and the 4-bit reference key in registers. It sequences count / clear / hold through a small FSM and reports completion over a valid/ready handshake, so downstream logic consumes one "run finished" event per start. It sits directly downstream of the combinational stage: it registers that stage's counter and compare results and feeds the counter back.

---
 rtl/lal_pkg.sv | 21 ++
 rtl/lal_seq_if.sv | 42 ++++
 rtl/lal_key_cmp.sv | 41 ++++
 rtl/lal_seq.sv | 94 +++++++++
 4 files changed

// File: rtl/lal_pkg.sv
// -----------------------------------------------------------------------------
// lal_pkg
// Shared definitions for the lal sequential control stage.
//   lal_state_e : run sequencer states (IDLE, COUNT, WAIT_ACK)
//   LAL_CNT_W   : default step counter width
//   LAL_KEY_W   : default key/reference width
//   LAL_TERM    : default terminal count
// -----------------------------------------------------------------------------
package lal_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNT    = 2'd1,
      WAIT_ACK = 2'd2
   } lal_state_e;

   localparam int                   LAL_CNT_W = 9;
   localparam int                   LAL_KEY_W = 4;
   localparam logic [LAL_CNT_W-1:0] LAL_TERM  = 9'h1FF;

endpackage

// File: rtl/lal_seq_if.sv
// -----------------------------------------------------------------------------
// lal_seq_if
// Control/status bundle between the lal sequencer and its surroundings.
//   key_pad, ref_pad, load_pad   : live key, reference value and its load strobe
//   start_pad, hold_pad, clr_pad : run control
//   cnt_pad, match_pad, busy_pad : registered status
//   done_valid_pad/done_ready_pad: run-complete handshake
// Modports: master drives the controls and consumes status; slave is the
// sequencer itself.
// -----------------------------------------------------------------------------
interface lal_seq_if
   import lal_pkg::*;
#(
   parameter int CNT_W = LAL_CNT_W,
   parameter int KEY_W = LAL_KEY_W
);

   logic [KEY_W-1:0] key_pad;
   logic [KEY_W-1:0] ref_pad;
   logic             load_pad;
   logic             start_pad;
   logic             hold_pad;
   logic             clr_pad;
   logic [CNT_W-1:0] cnt_pad;
   logic             match_pad;
   logic             busy_pad;
   logic             done_valid_pad;
   logic             done_ready_pad;

   modport master (
      output key_pad, ref_pad, load_pad, start_pad, hold_pad, clr_pad,
             done_ready_pad,
      input  cnt_pad, match_pad, busy_pad, done_valid_pad
   );

   modport slave (
      input  key_pad, ref_pad, load_pad, start_pad, hold_pad, clr_pad,
             done_ready_pad,
      output cnt_pad, match_pad, busy_pad, done_valid_pad
   );

endinterface

// File: rtl/lal_key_cmp.sv
// -----------------------------------------------------------------------------
// lal_key_cmp
// Reference register plus registered equality compare.
//   clk_pad : clock, rising edge
//   rst_pad : asynchronous active-high reset
//   key     : live key
//   ref_val : value loaded into the reference register when load is high
//   load    : reference load strobe (effective at all times)
//   match   : registered (key == reference), one cycle latency
// -----------------------------------------------------------------------------
module lal_key_cmp
   import lal_pkg::*;
#(
   parameter int KEY_W = LAL_KEY_W
) (
   input  logic             clk_pad,
   input  logic             rst_pad,
   input  logic [KEY_W-1:0] key,
   input  logic [KEY_W-1:0] ref_val,
   input  logic             load,
   output logic             match
);

   logic [KEY_W-1:0] ref_reg;

   // NOTE: non-blocking assignments make the compare read ref_reg as it was
   // before this edge, so a load and a compare in the same cycle see the old
   // reference.
   always_ff @(posedge clk_pad or posedge rst_pad) begin
      if (rst_pad) begin
         ref_reg <= '0;
         match   <= 1'b0;
      end else begin
         match <= (key == ref_reg);
         if (load) begin
            ref_reg <= ref_val;
         end
      end
   end

endmodule

// File: rtl/lal_seq.sv
// -----------------------------------------------------------------------------
// lal_seq
// Sequential control stage: step counter, run FSM and completion handshake
// around the lal next-state logic. One done event is produced per accepted
// start; reset aborts a run without producing one.
//   clk_pad : clock, rising edge
//   rst_pad : asynchronous active-high reset
//   bus     : lal_seq_if slave (controls in, counter/match/busy/done out)
// Parameters: CNT_W counter width, KEY_W key width, TERM terminal count.
// -----------------------------------------------------------------------------
module lal_seq
   import lal_pkg::*;
#(
   parameter int               CNT_W = LAL_CNT_W,
   parameter int               KEY_W = LAL_KEY_W,
   parameter logic [CNT_W-1:0] TERM  = CNT_W'(LAL_TERM)
) (
   input  logic        clk_pad,
   input  logic        rst_pad,
   lal_seq_if.slave    bus
);

   lal_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done_valid;

   lal_key_cmp #(
      .KEY_W (KEY_W)
   ) u_key_cmp (
      .clk_pad (clk_pad),
      .rst_pad (rst_pad),
      .key     (bus.key_pad),
      .ref_val (bus.ref_pad),
      .load    (bus.load_pad),
      .match   (bus.match_pad)
   );

   // busy and done_valid are registered alongside the state so every output
   // comes straight from a flop and is forced low the moment reset asserts.
   always_ff @(posedge clk_pad or posedge rst_pad) begin
      if (rst_pad) begin
         state      <= IDLE;
         cnt        <= '0;
         busy       <= 1'b0;
         done_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_pad) begin
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= COUNT;
               end
            end

            // Priority clr > hold > terminal > increment. The counter stops at
            // TERM, so it never wraps.
            COUNT: begin
               if (bus.clr_pad) begin
                  cnt <= '0;
               end else if (!bus.hold_pad) begin
                  if (cnt == TERM) begin
                     done_valid <= 1'b1;
                     state      <= WAIT_ACK;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            // start/clr/hold are ignored here; cnt keeps TERM.
            WAIT_ACK: begin
               if (bus.done_ready_pad) begin
                  done_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: begin
               done_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.cnt_pad        = cnt;
   assign bus.busy_pad       = busy;
   assign bus.done_valid_pad = done_valid;

endmodule
